// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the arithmetic unit: gathers a 5-byte command frame,
// fires the ALU once, then returns result low/high and a status byte.
module alu_cmd_sequencer #(
    parameter int          DATA_WIDTH = 16,
    parameter int          TIMEOUT    = 8,
    parameter logic [3:0]  FRAME_TAG  = 4'hA
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [7:0]            RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [3:0]            ALU_FUN,
    output logic                  Arith_EN,
    input  logic [DATA_WIDTH-1:0] Arith_OUT,
    input  logic                  ALU_Carry,
    input  logic                  Arith_Flag,
    output logic [7:0]            TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  CMD_ERR
);

    localparam int         NUM_LANES = 2 * DATA_WIDTH / 8;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_GET_AL = 4'd1,
        S_GET_AH = 4'd2,
        S_GET_BL = 4'd3,
        S_GET_BH = 4'd4,
        S_EXEC   = 4'd5,
        S_WAIT   = 4'd6,
        S_SEND_L = 4'd7,
        S_SEND_H = 4'd8,
        S_SEND_S = 4'd9
    } state_t;

    state_t                   state_reg;
    state_t                   state_next;
    logic [3:0]               fun_reg;
    logic [DATA_WIDTH-1:0]    result_reg;
    logic                     carry_reg;
    logic                     timeout_reg;
    logic [7:0]               wait_cnt_reg;
    logic                     cmd_err_reg;
    logic [NUM_LANES-1:0]     lane_we;
    logic [2*DATA_WIDTH-1:0]  operand_bus;
    logic                     tag_ok;
    logic                     wait_expired;

    assign tag_ok       = (RX_P_DATA[7:4] == FRAME_TAG);
    assign wait_expired = (wait_cnt_reg == WAIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (RST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (RX_D_VLD && tag_ok) state_next = S_GET_AL;
            S_GET_AL: if (RX_D_VLD) state_next = S_GET_AH;
            S_GET_AH: if (RX_D_VLD) state_next = S_GET_BL;
            S_GET_BL: if (RX_D_VLD) state_next = S_GET_BH;
            S_GET_BH: if (RX_D_VLD) state_next = S_EXEC;
            S_EXEC:   state_next = S_WAIT;
            S_WAIT:   if (Arith_Flag || wait_expired) state_next = S_SEND_L;
            S_SEND_L: if (!TX_BUSY) state_next = S_SEND_H;
            S_SEND_H: if (!TX_BUSY) state_next = S_SEND_S;
            S_SEND_S: if (!TX_BUSY) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output logic; TX_P_DATA is a pure function of state so it stays put under TX_BUSY
    always_comb begin
        Arith_EN  = 1'b0;
        TX_D_VLD  = 1'b0;
        TX_P_DATA = 8'h00;
        case (state_reg)
            S_EXEC: Arith_EN = 1'b1;
            S_SEND_L: begin
                TX_D_VLD  = 1'b1;
                TX_P_DATA = result_reg[7:0];
            end
            S_SEND_H: begin
                TX_D_VLD  = 1'b1;
                TX_P_DATA = result_reg[15:8];
            end
            S_SEND_S: begin
                TX_D_VLD  = 1'b1;
                TX_P_DATA = {6'b0, timeout_reg, carry_reg};
            end
            default: ;
        endcase
    end

    // Byte-lane write enables: lanes 0..1 form A, lanes 2..3 form B
    always_comb begin
        lane_we    = '0;
        lane_we[0] = RX_D_VLD && (state_reg == S_GET_AL);
        lane_we[1] = RX_D_VLD && (state_reg == S_GET_AH);
        lane_we[2] = RX_D_VLD && (state_reg == S_GET_BL);
        lane_we[3] = RX_D_VLD && (state_reg == S_GET_BH);
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [7:0] byte_reg;
        always_ff @(posedge clk) begin
            if (RST) begin
                byte_reg <= 8'h00;
            end else if (lane_we[gi]) begin
                byte_reg <= RX_P_DATA;
            end
        end
        assign operand_bus[gi*8 +: 8] = byte_reg;
    end

    assign A       = operand_bus[DATA_WIDTH-1:0];
    assign B       = operand_bus[2*DATA_WIDTH-1:DATA_WIDTH];
    assign ALU_FUN = fun_reg;
    assign CMD_ERR = cmd_err_reg;

    always_ff @(posedge clk) begin
        if (RST) begin
            fun_reg      <= 4'h0;
            result_reg   <= '0;
            carry_reg    <= 1'b0;
            timeout_reg  <= 1'b0;
            wait_cnt_reg <= 8'h00;
            cmd_err_reg  <= 1'b0;
        end else begin
            cmd_err_reg <= (state_reg == S_IDLE) && RX_D_VLD && !tag_ok;
            if ((state_reg == S_IDLE) && RX_D_VLD && tag_ok) begin
                fun_reg <= RX_P_DATA[3:0];
            end
            if (state_reg == S_EXEC) begin
                wait_cnt_reg <= 8'h00;
            end else if (state_reg == S_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
            // A flag on the last wait cycle still wins over the abort
            if (state_reg == S_WAIT) begin
                if (Arith_Flag) begin
                    result_reg  <= Arith_OUT;
                    carry_reg   <= ALU_Carry;
                    timeout_reg <= 1'b0;
                end else if (wait_expired) begin
                    result_reg  <= '0;
                    carry_reg   <= 1'b0;
                    timeout_reg <= 1'b1;
                end
            end
        end
    end

endmodule
